// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - Wishbone-slave 8N1 UART transmitter with TX FIFO and transmit-complete interrupt
module wb_uart_tx #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_o,
    output logic        tx_oeb_o,
    output logic        irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [AW:0] ONE_LEVEL  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   div;
    logic          ctrl_en;
    logic          ctrl_irq_en;

    state_t        state;
    logic [15:0]   bitdiv;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          wb_sel;
    logic          wr_en;
    logic [1:0]    reg_idx;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          frame_end;
    logic [15:0]   div_next;
    logic [31:0]   rd_data;
    logic          unused_ok;

    assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    // The !ack term keeps a request held through its ack cycle from being acked twice.
    assign wb_sel  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~wbs_ack_o;
    assign wr_en   = wb_sel & wbs_we_i;
    assign reg_idx = wbs_adr_i[3:2];

    assign empty     = (count == '0);
    assign full      = (count == FULL_LEVEL);
    assign push_req  = wr_en & (reg_idx == 2'd0) & wbs_sel_i[0];
    assign frame_end = (baud_cnt == bitdiv - 16'd1);
    assign pop       = ctrl_en & ~empty & ((state == IDLE) | ((state == STOP) & frame_end));
    assign push_ok   = push_req & (~full | pop);

    assign div_next = {wbs_sel_i[1] ? wbs_dat_i[15:8] : div[15:8],
                       wbs_sel_i[0] ? wbs_dat_i[7:0]  : div[7:0]};

    assign tx_oeb_o = ~ctrl_en;

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd1: begin
                rd_data[0]          = (state != IDLE);
                rd_data[1]          = full;
                rd_data[2]          = empty;
                rd_data[3]          = overflow;
                rd_data[8 +: AW+1]  = count;
            end
            2'd2:    rd_data[15:0] = div;
            2'd3:    rd_data[1:0]  = {ctrl_irq_en, ctrl_en};
            default: rd_data       = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            overflow    <= 1'b0;
            div         <= DEFAULT_DIV;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else begin
            wbs_ack_o <= wb_sel;
            wbs_dat_o <= (wb_sel & ~wbs_we_i) ? rd_data : '0;
            if (push_req & full & ~pop) begin
                overflow <= 1'b1;
            end else if (wr_en & (reg_idx == 2'd1) & wbs_sel_i[0] & wbs_dat_i[3]) begin
                overflow <= 1'b0;
            end
            if (wr_en & (reg_idx == 2'd2)) begin
                div <= (div_next == 16'd0) ? 16'd1 : div_next;
            end
            if (wr_en & (reg_idx == 2'd3) & wbs_sel_i[0]) begin
                ctrl_en     <= wbs_dat_i[0];
                ctrl_irq_en <= wbs_dat_i[1];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wbs_dat_i[7:0];
        end
    end

    // When full, a simultaneous pop frees the slot the push lands in, so the level stays put.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + ONE_LEVEL;
                2'b01:   count <= count - ONE_LEVEL;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            bitdiv   <= DEFAULT_DIV;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            irq_o    <= 1'b0;
        end else begin
            irq_o <= ctrl_irq_en & empty & (state == IDLE);
            if (pop) begin
                // DIV is latched per frame so a mid-frame write only affects the next frame.
                state    <= START;
                tx_o     <= 1'b0;
                shreg    <= mem[rd_ptr];
                bitdiv   <= div;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tx_o     <= 1'b1;
                        baud_cnt <= '0;
                    end
                    START: begin
                        if (frame_end) begin
                            state    <= DATA;
                            tx_o     <= shreg[0];
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (frame_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= shreg >> 1;
                                tx_o    <= shreg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    STOP: begin
                        if (frame_end) begin
                            state    <= IDLE;
                            tx_o     <= 1'b1;
                            baud_cnt <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb/tb_wb_uart_tx.sv - randomized self-checking bench for wb_uart_tx against a frame-level reference model
module tb_wb_uart_tx;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int LOGN = 16384;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic        tx;
    logic        oeb;
    logic        irq;

    wb_uart_tx #(.BASE_ADR(BASE), .DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .tx_o      (tx),
        .tx_oeb_o  (oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // pcnt = number of rising edges so far; log[n] holds the line value in the cycle after edge n.
    int   pcnt = 0;
    logic tx_log  [LOGN];
    logic irq_log [LOGN];
    always @(posedge clk) pcnt <= pcnt + 1;
    always @(negedge clk) begin
        if (pcnt < LOGN) begin
            tx_log[pcnt]  = tx;
            irq_log[pcnt] = irq;
        end
    end

    int          nchk = 0;
    int          nbad = 0;
    logic [7:0]  q[$];
    bit          ovf_m;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = 4'hf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("wb_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, BASE | 32'(off), d, dummy);
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [31:0] rd);
        wb_xfer(1'b0, BASE | 32'(off), 32'h0, rd);
    endtask

    function automatic logic [31:0] status_exp(input int lvl, input bit busy, input bit ov);
        return (32'(lvl) << 8) | (ov ? 32'h8 : 32'h0) | ((lvl == 0) ? 32'h4 : 32'h0)
             | ((lvl == 8) ? 32'h2 : 32'h0) | (busy ? 32'h1 : 32'h0);
    endfunction

    task automatic wait_log(input int idx);
        while (pcnt <= idx + 1) @(negedge clk);
    endtask

    // An 8N1 frame is start 0, data LSB first, stop 1, every bit held d cycles.
    task automatic check_frame(input string tag, input int start, input logic [7:0] b, input int d);
        logic exp_bit;
        int   bad;
        wait_log(start + 10 * d - 1);
        for (int i = 0; i < 10; i++) begin
            exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            bad = 0;
            for (int j = 0; j < d; j++) begin
                if (tx_log[start + i * d + j] !== exp_bit) bad++;
            end
            check($sformatf("%s_bit%0d_badcycles", tag, i), 32'(bad), 32'd0);
        end
    endtask

    task automatic check_idle(input string tag, input int start, input int n);
        int bad;
        wait_log(start + n - 1);
        bad = 0;
        for (int j = 0; j < n; j++) begin
            if (tx_log[start + j] !== 1'b1) bad++;
        end
        check($sformatf("%s_badcycles", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  a;
        logic [7:0]  b;
        int          t;
        int          d;
        int          d1;
        int          d2;
        int          p;
        int          badack;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_oeb", oeb, 1);
        check("rst_irq", irq, 0);
        check("rst_ack", ack, 0);
        rstn = 1'b1;
        wb_read(4'h8, rd); check("rst_div", rd, 32'd868);
        wb_read(4'h4, rd); check("rst_status", rd, 32'h004);
        wb_read(4'hC, rd); check("rst_ctrl", rd, 32'h0);

        wb_write(4'h8, 32'd4);
        wb_write(4'hC, 32'h3);
        repeat (2) @(negedge clk);
        check("irq_idle_empty", irq, 1);
        check("oeb_enabled", oeb, 0);
        wb_write(4'h0, 32'hA5);
        t = pcnt;
        check_frame("a5", t + 1, 8'hA5, 4);
        wait_log(t + 42);
        check("a5_pre_frame_tx", tx_log[t], 1);
        check("a5_post_frame_tx", tx_log[t + 41], 1);
        check("a5_irq_mid_frame", irq_log[t + 20], 0);
        check("a5_irq_at_idle_entry", irq_log[t + 41], 0);
        check("a5_irq_rise", irq_log[t + 42], 1);

        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(2, 6);
            b = 8'($urandom);
            wb_write(4'h8, 32'(d));
            wb_write(4'h0, 32'(b));
            t = pcnt;
            check_frame($sformatf("rnd%0d", k), t + 1, b, d);
            wait_log(t + 10 * d + 2);
        end

        wb_write(4'h8, 32'd0);
        wb_read(4'h8, rd); check("div_zero_as_one", rd, 32'd1);
        b = 8'($urandom);
        wb_write(4'h0, 32'(b));
        t = pcnt;
        check_frame("div1", t + 1, b, 1);
        wait_log(t + 12);

        wb_write(4'hC, 32'h0);
        check("oeb_disabled", oeb, 1);
        d = $urandom_range(2, 5);
        wb_write(4'h8, 32'(d));
        q.delete();
        ovf_m = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b = 8'($urandom);
            wb_write(4'h0, 32'(b));
            if (q.size() < 8) q.push_back(b);
            else ovf_m = 1'b1;
        end
        wb_read(4'h4, rd); check("ovf_status", rd, status_exp(q.size(), 1'b0, ovf_m));
        wb_write(4'h4, 32'h8);
        ovf_m = 1'b0;
        wb_read(4'h4, rd); check("ovf_cleared", rd, status_exp(q.size(), 1'b0, ovf_m));
        wb_write(4'hC, 32'h1);
        t = pcnt;
        for (int k = 0; k < 8; k++) begin
            check_frame($sformatf("ovf_f%0d", k), t + 1 + 10 * d * k, q[k], d);
        end
        check_idle("ovf_no_ninth", t + 1 + 80 * d, 10 * d);
        wb_read(4'h4, rd); check("ovf_drained", rd, status_exp(0, 1'b0, 1'b0));
        q.delete();

        wb_write(4'hC, 32'h0);
        d = $urandom_range(2, 4);
        wb_write(4'h8, 32'(d));
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            wb_write(4'h0, 32'(b));
            q.push_back(b);
        end
        wb_write(4'hC, 32'h1);
        t = pcnt;
        b = 8'($urandom);
        wb_write(4'h0, 32'(b));
        check("refill_commit_edge", 32'(pcnt), 32'(t + 2));
        q.push_back(b);
        p = t + 1 + 10 * d;
        while (pcnt < p - 1) @(negedge clk);
        a = 8'($urandom);
        wb_write(4'h0, 32'(a));
        check("pushpop_commit_edge", 32'(pcnt), 32'(p));
        q.push_back(a);
        wb_read(4'h4, rd); check("pushpop_status", rd, status_exp(q.size() - 2, 1'b1, 1'b0));

        while (pcnt < t + 1 + 20 * d) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_oeb", oeb, 1);
        rstn = 1'b1;
        check_frame("pp_f0", t + 1, q[0], d);
        check_frame("pp_f1", t + 1 + 10 * d, q[1], d);
        check("pp_f2_start_bit", tx_log[t + 1 + 20 * d], 0);
        q.delete();
        wb_read(4'h4, rd); check("rst_mid_status", rd, 32'h004);
        wb_read(4'h8, rd); check("rst_mid_div", rd, 32'd868);

        d1 = $urandom_range(2, 4);
        d2 = $urandom_range(5, 7);
        wb_write(4'h8, 32'(d1));
        a = 8'($urandom);
        b = 8'($urandom);
        wb_write(4'h0, 32'(a));
        wb_write(4'h0, 32'(b));
        wb_write(4'hC, 32'h1);
        t = pcnt;
        while (pcnt < t + 3) @(negedge clk);
        wb_write(4'h8, 32'(d2));
        check_frame("divchg_f1", t + 1, a, d1);
        check_frame("divchg_f2", t + 1 + 10 * d1, b, d2);
        check_idle("divchg_after", t + 1 + 10 * d1 + 10 * d2, 8);
        wb_read(4'h4, rd); check("divchg_status", rd, status_exp(0, 1'b0, 1'b0));

        wb_write(4'hC, 32'h0);
        d = $urandom_range(2, 4);
        wb_write(4'h8, 32'(d));
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            wb_write(4'h0, 32'(b));
            q.push_back(b);
        end
        wb_write(4'hC, 32'h1);
        t = pcnt;
        check("en_oeb_low", oeb, 0);
        while (pcnt < t + 5) @(negedge clk);
        wb_write(4'hC, 32'h0);
        check("en_oeb_high_now", oeb, 1);
        check_frame("en_f1", t + 1, q[0], d);
        check_idle("en_hold_idle", t + 1 + 10 * d, 10 * d);
        void'(q.pop_front());
        wb_read(4'h4, rd); check("en_status", rd, status_exp(q.size(), 1'b0, 1'b0));

        badack = 0;
        for (int k = 0; k < 10; k++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hf;
            dat_w = $urandom | 32'hB;
            adr = (BASE ^ (32'h10 << $urandom_range(0, 27))) | (32'($urandom_range(0, 3)) << 2);
            @(negedge clk);
            if (ack) badack++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("badadr_acks", 32'(badack), 32'd0);
        wb_read(4'h8, rd); check("badadr_div", rd, 32'(d));
        wb_read(4'hC, rd); check("badadr_ctrl", rd, 32'h0);
        wb_read(4'h4, rd); check("badadr_status", rd, status_exp(q.size(), 1'b0, 1'b0));
        wb_read(4'h0, rd); check("data_reads_zero", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end
endmodule
